// File: rtl/line_refill_unit.sv
// line_refill_unit: fetches one 128-bit instruction-cache line from 32-bit instruction memory.
// Latency: accept at T, line_valid at T+1+sum(per-word memory latency + 1); T+9 with 1-cycle memory.
// Backpressure: req_ready only in IDLE; one refill and at most one memory read outstanding at a time.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   req_valid/req_addr  refill request (byte address of the missing instruction)
//   req_ready           high only while idle; request accepted on req_valid & req_ready
//   abort               branch redirect; cancels the refill in flight
//   mem_rd/mem_addr     one-cycle read strobe and word-aligned byte address
//   mem_rvalid/rdata    read return, any latency >= 1 cycle after mem_rd
//   line_valid          one-cycle pulse, line_addr/line_data complete
//   line_addr/line_data line-aligned address and assembled line (word k at bits [32k+31:32k])
//
// Build option: define CRITICAL_WORD_FIRST_EN to start each refill at the word that missed
// (req_addr word offset) and wrap around the line; otherwise words are read 0,1,2,3.

module line_refill_unit #(
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  input  logic [ADDR_W-1:0]            req_addr,
  output logic                         req_ready,
  input  logic                         abort,
  output logic                         mem_rd,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic                         mem_rvalid,
  input  logic [31:0]                  mem_rdata,
  output logic                         line_valid,
  output logic [ADDR_W-1:0]            line_addr,
  output logic [32*WORDS_PER_LINE-1:0] line_data
);

  // Word index width, byte offset of a line, and width of the received-word count.
  localparam int WORD_W = $clog2(WORDS_PER_LINE);
  localparam int OFF_W  = WORD_W + 2;
  localparam int CNT_W  = $clog2(WORDS_PER_LINE + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS_PER_LINE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [WORD_W-1:0]                word_q;   // slot being read; wraps naturally
  logic [CNT_W-1:0]                 rcvd_q;   // words received so far, decides completion
  logic [ADDR_W-OFF_W-1:0]          tag_q;    // line address without the offset bits
  logic [WORDS_PER_LINE-1:0][31:0]  slot_q;   // assembled line, one slot per word

  logic [WORD_W-1:0] start_word;
  logic              accept;
  logic              take_word;

`ifdef CRITICAL_WORD_FIRST_EN
  assign start_word = req_addr[OFF_W-1:2];
`else
  assign start_word = '0;
`endif

  // Offset bits are only partly used (or not at all) depending on the build option.
  logic unused_req_offset;
  assign unused_req_offset = ^req_addr[OFF_W-1:0];

  // A request is taken in IDLE even if abort is high: abort only cancels work in flight.
  assign accept = (state_q == S_IDLE) && req_valid;

  // Data returned together with an abort is dropped, never written into the line.
  assign take_word = (state_q == S_WAIT) && mem_rvalid && !abort;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // Abort before the strobe leaves: nothing is outstanding, go straight home.
        state_d = abort ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (abort) begin
          // A read is outstanding unless it is returning right now.
          state_d = mem_rvalid ? S_IDLE : S_DRAIN;
        end else if (mem_rvalid) begin
          state_d = (rcvd_q == LAST_CNT) ? S_DONE : S_REQ;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_DRAIN: begin
        // Swallow the orphaned read so it cannot land in a later refill.
        if (mem_rvalid) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready  = 1'b0;
    mem_rd     = 1'b0;
    mem_addr   = '0;
    line_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
      end
      S_REQ: begin
        mem_rd = !abort;
        if (!abort) begin
          mem_addr = {tag_q, word_q, 2'b00};
        end
      end
      S_DONE: begin
        line_valid = !abort;
      end
      default: begin
      end
    endcase
  end

  assign line_addr = {tag_q, {OFF_W{1'b0}}};
  assign line_data = slot_q;

  // ---------------------------------------------------------------------------
  // Datapath: line address, word pointer, received count and line slots.
  // Slots are not cleared on accept; stale words are only visible outside
  // line_valid, where line_data carries no meaning.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_q  <= '0;
      word_q <= '0;
      rcvd_q <= '0;
      slot_q <= '0;
    end else if (accept) begin
      tag_q  <= req_addr[ADDR_W-1:OFF_W];
      word_q <= start_word;
      rcvd_q <= '0;
    end else if (take_word) begin
      slot_q[word_q] <= mem_rdata;
      word_q         <= word_q + 1'b1;
      rcvd_q         <= rcvd_q + 1'b1;
    end
  end

endmodule
